// File: rtl/sram_block_mover_if.sv
// Bundle of control, SRAM and cipher-stream signals seen by the block mover.
interface sram_block_mover_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        num_blocks;
    logic              busy;
    logic              done;
    logic              err;
    logic              sram_read;
    logic              sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic [DATA_W-1:0] blk_out_data;
    logic              blk_out_valid;
    logic              blk_out_ready;
    logic [DATA_W-1:0] blk_in_data;
    logic              blk_in_valid;
    logic              blk_in_ready;

    modport master (
        input  start, abort, src_addr, dst_addr, num_blocks,
        input  sram_rdata, blk_out_ready, blk_in_data, blk_in_valid,
        output busy, done, err, sram_read, sram_write, sram_addr, sram_wdata,
        output blk_out_data, blk_out_valid, blk_in_ready
    );

    modport slave (
        output start, abort, src_addr, dst_addr, num_blocks,
        output sram_rdata, blk_out_ready, blk_in_data, blk_in_valid,
        input  busy, done, err, sram_read, sram_write, sram_addr, sram_wdata,
        input  blk_out_data, blk_out_valid, blk_in_ready
    );
endinterface

// File: rtl/sram_block_mover.sv
// Moves a run of 16-byte blocks SRAM -> cipher core -> SRAM, one block in flight.
//
// state   | meaning
// IDLE    | waiting for start
// CHECK   | zero-count and range check on the latched request
// RD_REQ  | SRAM read strobe at the current source address
// RD_WAIT | waiting out the read latency, capture read data on the last cycle
// OUT     | offering the block to the cipher core
// IN      | accepting the processed block back
// WR      | SRAM write strobe at the current destination address
// FIN     | one-cycle done pulse
module sram_block_mover #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 128,
    parameter int BLK_BYTES = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    sram_block_mover_if.master  bus
);
    localparam int EW    = ADDR_W + 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [EW-1:0] LIMIT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_OUT, S_IN, S_WR, S_FIN
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cur_src_q;
    logic [ADDR_W-1:0] cur_dst_q;
    logic [7:0]        rem_q;
    logic [LAT_W-1:0]  lat_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              sram_read_q;
    logic              sram_write_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [DATA_W-1:0] blk_out_data_q;
    logic              blk_out_valid_q;
    logic              blk_in_ready_q;

    // Range check is done one bit wider so an exact fit to the top of memory passes.
    logic [EW-1:0] span;
    logic [EW-1:0] src_end;
    logic [EW-1:0] dst_end;
    logic          range_bad;

    assign span      = EW'(rem_q) * EW'(BLK_BYTES);
    assign src_end   = EW'(cur_src_q) + span;
    assign dst_end   = EW'(cur_dst_q) + span;
    assign range_bad = (src_end > LIMIT) || (dst_end > LIMIT);

    // Sequencer with all outputs registered; abort overrides every non-idle state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= S_IDLE;
            cur_src_q       <= '0;
            cur_dst_q       <= '0;
            rem_q           <= '0;
            lat_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            sram_read_q     <= 1'b0;
            sram_write_q    <= 1'b0;
            sram_addr_q     <= '0;
            sram_wdata_q    <= '0;
            blk_out_data_q  <= '0;
            blk_out_valid_q <= 1'b0;
            blk_in_ready_q  <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
            if (bus.abort && state_q != S_IDLE) begin
                state_q         <= S_IDLE;
                busy_q          <= 1'b0;
                blk_out_valid_q <= 1'b0;
                blk_in_ready_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            cur_src_q <= bus.src_addr;
                            cur_dst_q <= bus.dst_addr;
                            rem_q     <= bus.num_blocks;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (rem_q == 8'd0 || range_bad) begin
                            err_q   <= range_bad && (rem_q != 8'd0);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_FIN;
                        end else begin
                            sram_read_q <= 1'b1;
                            sram_addr_q <= cur_src_q;
                            state_q     <= S_RD_REQ;
                        end
                    end
                    S_RD_REQ: begin
                        lat_q   <= '0;
                        state_q <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (lat_q == LAT_W'(RD_LAT - 1)) begin
                            blk_out_data_q  <= bus.sram_rdata;
                            blk_out_valid_q <= 1'b1;
                            state_q         <= S_OUT;
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (bus.blk_out_ready) begin
                            blk_out_valid_q <= 1'b0;
                            blk_in_ready_q  <= 1'b1;
                            state_q         <= S_IN;
                        end
                    end
                    S_IN: begin
                        if (bus.blk_in_valid) begin
                            blk_in_ready_q <= 1'b0;
                            sram_write_q   <= 1'b1;
                            sram_addr_q    <= cur_dst_q;
                            sram_wdata_q   <= bus.blk_in_data;
                            state_q        <= S_WR;
                        end
                    end
                    S_WR: begin
                        cur_src_q <= cur_src_q + ADDR_W'(BLK_BYTES);
                        cur_dst_q <= cur_dst_q + ADDR_W'(BLK_BYTES);
                        rem_q     <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_FIN;
                        end else begin
                            sram_read_q <= 1'b1;
                            sram_addr_q <= cur_src_q + ADDR_W'(BLK_BYTES);
                            state_q     <= S_RD_REQ;
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.sram_read     = sram_read_q;
    assign bus.sram_write    = sram_write_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_wdata    = sram_wdata_q;
    assign bus.blk_out_data  = blk_out_data_q;
    assign bus.blk_out_valid = blk_out_valid_q;
    assign bus.blk_in_ready  = blk_in_ready_q;
endmodule
